// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and FSM state type for uart_rx (PARITY state under UART_RX_PARITY_EN)
package uart_pkg;

    localparam int DEF_CLKS_PER_BIT = 868;
    localparam int DEF_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-data bundle of uart_rx (parity_err present under UART_RX_PARITY_EN)
interface uart_rx_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS
);

    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 frame_err;
    logic                 busy;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err;
`endif

    modport master (
        output data_out,
        output data_valid,
        output frame_err,
`ifdef UART_RX_PARITY_EN
        output parity_err,
`endif
        output busy
    );

    modport slave (
        input data_out,
        input data_valid,
        input frame_err,
`ifdef UART_RX_PARITY_EN
        input parity_err,
`endif
        input busy
    );

endinterface

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer for the serial line, resets to the idle-high level
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous line; both stages reset to line-idle (high)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver, 8N1 by default, even parity check when UART_RX_PARITY_EN is defined
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rx,
    uart_rx_if.master rx_if
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    // Sample points: mid start bit after half a bit, then every full bit
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic                 rx_s;
    logic                 rx_prev_q;
    logic                 fall_q;
    logic                 fall_d;

    state_t               state_q;
    logic [CNT_W-1:0]     baud_q;
    logic [BIT_W-1:0]     bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 busy_q;
    logic                 par_bad;
`ifdef UART_RX_PARITY_EN
    logic                 par_q;
    logic                 perr_q;
`endif

    uart_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rx_s)
    );

    // A start is a high-to-low transition of the synchronized line, never a held low level
    assign fall_d = rx_prev_q & ~rx_s;

`ifdef UART_RX_PARITY_EN
    // Even parity: data bits plus the received parity bit must XOR to zero
    assign par_bad = ^{shift_q, par_q};
`else
    assign par_bad = 1'b0;
`endif

    // Remember the last line level and the last cycle's edge, so an edge landing on the
    // final STOP cycle is still seen once the FSM is back in IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_prev_q <= 1'b1;
            fall_q    <= 1'b0;
        end else begin
            rx_prev_q <= rx_s;
            fall_q    <= fall_d;
        end
    end

    // Frame FSM with baud/bit counters, shift register and registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    baud_q <= '0;
                    bit_q  <= '0;
                    if (fall_d || fall_q) begin
                        state_q <= S_START;
                        busy_q  <= 1'b1;
                    end
                end

                S_START: begin
                    if (baud_q == CNT_HALF) begin
                        baud_q <= '0;
                        if (!rx_s) begin
                            state_q <= S_DATA;
                        end else begin
                            // Line already high again mid start bit: treat as a glitch
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        baud_q <= baud_q + CNT_W'(1);
                    end
                end

                S_DATA: begin
                    if (baud_q == CNT_LAST) begin
                        baud_q  <= '0;
                        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                        if (bit_q == BIT_LAST) begin
                            bit_q   <= '0;
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end else begin
                            bit_q <= bit_q + BIT_W'(1);
                        end
                    end else begin
                        baud_q <= baud_q + CNT_W'(1);
                    end
                end

`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (baud_q == CNT_LAST) begin
                        baud_q  <= '0;
                        par_q   <= rx_s;
                        state_q <= S_STOP;
                    end else begin
                        baud_q <= baud_q + CNT_W'(1);
                    end
                end
`endif

                S_STOP: begin
                    if (baud_q == CNT_LAST) begin
                        baud_q  <= '0;
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        // A low stop bit is reported as a framing error only; parity is
                        // judged on frames that are otherwise well formed
                        if (!rx_s) begin
                            ferr_q <= 1'b1;
                        end else if (par_bad) begin
`ifdef UART_RX_PARITY_EN
                            perr_q <= 1'b1;
`endif
                        end else begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + CNT_W'(1);
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_if.data_out   = data_q;
    assign rx_if.data_valid = valid_q;
    assign rx_if.frame_err  = ferr_q;
    assign rx_if.busy       = busy_q;
`ifdef UART_RX_PARITY_EN
    assign rx_if.parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with randomized frames and a frame-level model
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int DB  = 8;
`ifdef UART_RX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int LAT = 2 + CPB / 2 + (DB + 1 + PBITS) * CPB + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx  = 1'b1;

    always #5 clk = ~clk;

    uart_rx_if #(.DATA_BITS(DB)) rif ();

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .rx    (rx),
        .rx_if (rif)
    );

    int checks = 0;
    int errors = 0;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            n_valid = 0;
    int            n_ferr  = 0;
    int            n_perr  = 0;
    int            n_both  = 0;
    int unsigned   last_valid_cyc = 0;
    logic [DB-1:0] got_q[$];

    always @(negedge clk) begin
        if (rst) begin
            if (rif.data_valid) begin
                n_valid++;
                got_q.push_back(rif.data_out);
                last_valid_cyc = cyc;
            end
            if (rif.frame_err) n_ferr++;
            if (rif.data_valid && rif.frame_err) n_both++;
`ifdef UART_RX_PARITY_EN
            if (rif.parity_err) n_perr++;
`endif
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'b1);
    endtask

    // par_bad flips the parity bit away from even parity (ignored without parity)
    task automatic send_frame(input logic [DB-1:0] d, input logic stop, input logic par_bad,
                              output int unsigned t0);
        t0 = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ par_bad);
`endif
        drive_bit(stop);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned   t0;
        int            bv, bf, bp, lat, drop;
        logic          busy_hi;
        logic [DB-1:0] d;
        logic          stop, pb;
        int            gap;
        logic [DB-1:0] exp_q[$];
        int            exp_ferr, exp_perr;

        repeat (3) @(posedge clk);
        #1;
        check("rst_data_out", 32'(rif.data_out), 32'h0);
        check("rst_busy", 32'(rif.busy), 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_valid", 32'(rif.data_valid), 32'h0);
        check("post_rst_ferr", 32'(rif.frame_err), 32'h0);
        idle_bits(1);

        // Single good frame with latency check
        bv = n_valid; bf = n_ferr; got_q.delete();
        send_frame(8'h95, 1'b1, 1'b0, t0);
        idle_bits(1);
        check("x95_valid_cnt", 32'(n_valid - bv), 32'd1);
        check("x95_ferr_cnt", 32'(n_ferr - bf), 32'd0);
        check("x95_data_out", 32'(rif.data_out), 32'h95);
        lat = int'(last_valid_cyc - t0);
        check("x95_latency_ok", 32'(lat >= LAT - 1 && lat <= LAT + 1), 32'd1);

        // Back-to-back frames with no idle between stop and next start
        bv = n_valid; got_q.delete();
        send_frame(8'hA5, 1'b1, 1'b0, t0);
        send_frame(8'h3C, 1'b1, 1'b0, t0);
        idle_bits(1);
        check("b2b_valid_cnt", 32'(n_valid - bv), 32'd2);
        check("b2b_count_q", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            check("b2b_first", 32'(got_q[0]), 32'hA5);
            check("b2b_second", 32'(got_q[1]), 32'h3C);
        end

        // Stop bit low: framing error, data_out unchanged
        bv = n_valid; bf = n_ferr;
        send_frame(8'h55, 1'b0, 1'b0, t0);
        idle_bits(1);
        check("ferr_cnt", 32'(n_ferr - bf), 32'd1);
        check("ferr_no_valid", 32'(n_valid - bv), 32'd0);
        check("ferr_data_kept", 32'(rif.data_out), 32'h3C);
        check("ferr_both", 32'(n_both), 32'd0);

        // Four-cycle low glitch must not produce a frame
        bv = n_valid; bf = n_ferr;
        busy_hi = 1'b0; drop = -1;
        rx = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (k == 4) rx = 1'b1;
            if (rif.busy) busy_hi = 1'b1;
            else if (busy_hi && drop < 0) drop = k;
        end
        check("glitch_busy_seen", 32'(busy_hi), 32'd1);
        check("glitch_busy_drop_ok", 32'(drop > 0 && drop <= CPB / 2 + 3), 32'd1);
        check("glitch_no_valid", 32'(n_valid - bv), 32'd0);
        check("glitch_no_ferr", 32'(n_ferr - bf), 32'd0);
        idle_bits(1);

        // Reset in the middle of 0xFF data bits, then a clean 0x0F
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        rx = 1'b1;
        repeat (4 * CPB + 3) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("midrst_data_out", 32'(rif.data_out), 32'h0);
        check("midrst_busy", 32'(rif.busy), 32'h0);
        check("midrst_valid", 32'(rif.data_valid), 32'h0);
        check("midrst_ferr", 32'(rif.frame_err), 32'h0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        bv = n_valid; bf = n_ferr; got_q.delete();
        idle_bits(2);
        check("midrst_no_pulse", 32'(n_valid - bv + n_ferr - bf), 32'd0);
        send_frame(8'h0F, 1'b1, 1'b0, t0);
        idle_bits(1);
        check("after_rst_valid_cnt", 32'(n_valid - bv), 32'd1);
        check("after_rst_data", 32'(rif.data_out), 32'h0F);

`ifdef UART_RX_PARITY_EN
        bv = n_valid; bp = n_perr;
        send_frame(8'h95, 1'b1, 1'b0, t0);
        idle_bits(1);
        check("par_ok_valid", 32'(n_valid - bv), 32'd1);
        check("par_ok_perr", 32'(n_perr - bp), 32'd0);
        bv = n_valid; bp = n_perr;
        send_frame(8'h95, 1'b1, 1'b1, t0);
        idle_bits(1);
        check("par_bad_perr", 32'(n_perr - bp), 32'd1);
        check("par_bad_no_valid", 32'(n_valid - bv), 32'd0);
        check("par_bad_data_kept", 32'(rif.data_out), 32'h95);
`endif

        // Randomized frames against the frame-level model
        bv = n_valid; bf = n_ferr; bp = n_perr; got_q.delete();
        exp_ferr = 0; exp_perr = 0;
        for (int k = 0; k < 24; k++) begin
            d    = DB'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            pb   = (PBITS != 0) && ($urandom_range(0, 3) == 0);
            send_frame(d, stop, pb, t0);
            if (!stop)   exp_ferr++;
            else if (pb) exp_perr++;
            else         exp_q.push_back(d);
            // After a low stop bit the line must rise before a new start edge exists
            gap = stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
            idle_bits(gap);
        end
        idle_bits(1);
        check("rand_valid_cnt", 32'(n_valid - bv), 32'(exp_q.size()));
        check("rand_ferr_cnt", 32'(n_ferr - bf), 32'(exp_ferr));
        check("rand_perr_cnt", 32'(n_perr - bp), 32'(PBITS != 0 ? exp_perr : 0));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("rand_data_%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        if (exp_q.size() > 0)
            check("rand_last_data_out", 32'(rif.data_out), 32'(exp_q[exp_q.size() - 1]));
        check("never_valid_and_ferr", 32'(n_both), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk cycles per serial bit (100 MHz / 115200 baud); legal values are integers >= 4.
REQ-002 Parameter DATA_BITS, default 8, number of data bits per frame.
REQ-003 clk  input  1  system clock; all flops are rising-edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 rx  input  1  serial line; idles high; frame is start(0), data LSB first, [parity], stop(1).
REQ-006 data_out  output  DATA_BITS  last correctly framed byte; holds its value until the next good frame.
REQ-007 data_valid  output  1  one-cycle pulse when data_out is updated.
REQ-008 frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-009 busy  output  1  high in every state except IDLE.

Function
REQ-010 rx shall pass through a 2-flop synchronizer; all logic shall use only the synchronized value rx_s.
REQ-011 FSM states: IDLE, START, DATA, [PARITY], STOP.
REQ-012 IDLE: on a rx_s high-to-low edge -> START with the bit counter cleared; a line held low never re-triggers the FSM.
REQ-013 START: after CLKS_PER_BIT/2 cycles, sample rx_s; if low -> DATA with the baud counter cleared; if high (glitch) -> IDLE with no output pulse.
REQ-014 DATA: sample every CLKS_PER_BIT cycles (mid-bit) and shift right into the shift register, MSB in, so the first bit lands in bit 0 after DATA_BITS samples.
REQ-015 After DATA_BITS samples -> PARITY if enabled, else STOP.
REQ-016 STOP: sample after CLKS_PER_BIT cycles.
  - High: data_out <= shift register, data_valid = 1 for one cycle.
  - Low: frame_err = 1 for one cycle, data_out unchanged.
  - Either case: -> IDLE.
REQ-017 data_valid and frame_err shall never assert in the same cycle.
REQ-018 Latency: data_valid rises 2 + CLKS_PER_BIT/2 + (DATA_BITS+1[+1])*CLKS_PER_BIT + 1 cycles after the rx falling edge at the pin, +/-1 cycle.
REQ-019 The baud counter shall be sized $clog2(CLKS_PER_BIT) bits, count from 0 to CLKS_PER_BIT-1, and wrap to 0 at each sample point.
REQ-020 A start edge arriving in the same cycle the STOP sample completes shall be detected in IDLE on the next cycle, so back-to-back frames are received.

Reset
REQ-021 rst low shall immediately force: state IDLE, counters 0, shift register 0, data_out 0, data_valid 0, frame_err 0, busy 0, synchronizer flops 1.
REQ-022 Reset asserted mid-frame shall abort the frame with no pulse; after release, the FSM waits for a fresh high-to-low edge.

Configuration
REQ-023 Macro UART_RX_PARITY_EN defined: add the PARITY state and an output parity_err (output, 1 bit).
  - One bit is sampled after the data bits; even parity is checked over data plus parity bit.
  - Mismatch: parity_err pulses one cycle at the stop sample, data_valid is suppressed, data_out is unchanged.
REQ-024 Macro not defined: no PARITY state and no parity_err port; frame length is DATA_BITS+2 bits.

Structure
REQ-025 Shared package uart_pkg shall hold the FSM state enum and the default CLKS_PER_BIT and DATA_BITS constants.
REQ-026 The synchronizer shall be a separate sub-module, uart_sync2 (1-bit, reset value 1, active-low async reset).

Verification (CLKS_PER_BIT=16, clk period 10 ns)
REQ-027 Reset, then send 0x95 (8'b10010101) with stop=1 -> data_out=0x95, data_valid pulses once, frame_err stays 0.
REQ-028 Send 0xA5 then 0x3C back-to-back with no idle gap -> two data_valid pulses, data_out 0xA5 then 0x3C.
REQ-029 Send 0x55 with the stop bit driven 0 -> frame_err pulses once, no data_valid, data_out keeps its prior value.
REQ-030 rx low pulse of 4 clk cycles -> FSM returns to IDLE, no pulses, busy deasserted within CLKS_PER_BIT/2+3 cycles.
REQ-031 Assert rst low midway through the data bits of 0xFF -> all outputs 0 immediately; the next frame, 0x0F, is received correctly.
REQ-032 UART_RX_PARITY_EN defined: send 0x95 with parity bit 0 -> data_valid; send 0x95 with parity bit 1 -> parity_err pulse, no data_valid.
